// File: rtl/rv32_branch_pkg.sv
// Shared RV32 branch definitions: funct3 encodings, controller FSM states and request payload.
package rv32_branch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned FCNT_W = 4;

    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } state_e;

    typedef struct packed {
        logic [F3_W-1:0] funct3;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
    } br_req_t;

    // Branch target wraps modulo 2^32.
    function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc,
                                                      input logic [XLEN-1:0] imm);
        return pc + imm;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Branch request / redirect / pipeline-control bundle between issue, controller and fetch.
interface branch_redirect_ctrl_if;
    import rv32_branch_pkg::*;

    logic            br_valid;
    logic            br_ready;
    logic [F3_W-1:0] br_funct3;
    logic [XLEN-1:0] br_rs1;
    logic [XLEN-1:0] br_rs2;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_imm;
    logic            redir_valid;
    logic            redir_ready;
    logic [XLEN-1:0] redir_pc;
    logic            flush;
    logic            stall;
    logic            misalign_err;

    modport master (
        output br_valid, br_funct3, br_rs1, br_rs2, br_pc, br_imm, redir_ready,
        input  br_ready, redir_valid, redir_pc, flush, stall, misalign_err
    );

    modport slave (
        input  br_valid, br_funct3, br_rs1, br_rs2, br_pc, br_imm, redir_ready,
        output br_ready, redir_valid, redir_pc, flush, stall, misalign_err
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational RV32 branch condition evaluator; reserved funct3 codes resolve not-taken.
module branch_cond
    import rv32_branch_pkg::*;
(
    input  logic [F3_W-1:0] funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_c_o
);

    logic eq_c;
    logic lt_c;
    logic ltu_c;

    assign eq_c  = (rs1_i == rs2_i);
    assign lt_c  = ($signed(rs1_i) < $signed(rs2_i));
    assign ltu_c = (rs1_i < rs2_i);

    always_comb begin
        taken_c_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_c_o = eq_c;
            F3_BNE:  taken_c_o = !eq_c;
            F3_BLT:  taken_c_o = lt_c;
            F3_BGE:  taken_c_o = !lt_c;
            F3_BLTU: taken_c_o = ltu_c;
            F3_BGEU: taken_c_o = !ltu_c;
            default: taken_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch resolve controller: capture -> evaluate -> redirect fetch -> flush younger stages.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_redirect_ctrl
    import rv32_branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_redirect_ctrl_if.slave  br_bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [XLEN-1:0]        taken_cnt_o,
    output logic [XLEN-1:0]        not_taken_cnt_o
`endif
);

    state_e            state_q, state_d;
    br_req_t           req_q, req_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              misalign_d;
    logic              taken_c;
    logic [XLEN-1:0]   target_c;

    logic              br_ready_q;
    logic              redir_valid_q;
    logic [XLEN-1:0]   redir_pc_q;
    logic              flush_q;
    logic              stall_q;
    logic              misalign_q;

    branch_cond u_cond (
        .funct3_i  (req_q.funct3),
        .rs1_i     (req_q.rs1),
        .rs2_i     (req_q.rs2),
        .taken_c_o (taken_c)
    );

    assign target_c = branch_target(req_q.pc, req_q.imm);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        fcnt_d     = fcnt_q;
        misalign_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (br_bus.br_valid) begin
                    req_d = '{funct3: br_bus.br_funct3, rs1: br_bus.br_rs1, rs2: br_bus.br_rs2,
                              pc: br_bus.br_pc, imm: br_bus.br_imm};
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (!taken_c) begin
                    state_d = IDLE;
                end else if (target_c[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (br_bus.redir_ready) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - FCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_q         <= '0;
            fcnt_q        <= '0;
            br_ready_q    <= 1'b1;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            fcnt_q        <= fcnt_d;
            br_ready_q    <= (state_d == IDLE);
            redir_valid_q <= (state_d == REDIRECT);
            redir_pc_q    <= (state_d == REDIRECT) ? target_c : '0;
            flush_q       <= (state_d == FLUSH);
            stall_q       <= (state_d != IDLE);
            misalign_q    <= misalign_d;
        end
    end

    assign br_bus.br_ready     = br_ready_q;
    assign br_bus.redir_valid  = redir_valid_q;
    assign br_bus.redir_pc     = redir_pc_q;
    assign br_bus.flush        = flush_q;
    assign br_bus.stall        = stall_q;
    assign br_bus.misalign_err = misalign_q;

`ifdef BRANCH_STATS_EN
    logic [XLEN-1:0] taken_cnt_q;
    logic [XLEN-1:0] not_taken_cnt_q;

    // Misaligned taken branches still count as taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else if (state_q == EVAL) begin
            if (taken_c && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + XLEN'(1);
            end else if (!taken_c && (not_taken_cnt_q != '1)) begin
                not_taken_cnt_q <= not_taken_cnt_q + XLEN'(1);
            end
        end
    end

    assign taken_cnt_o     = taken_cnt_q;
    assign not_taken_cnt_o = not_taken_cnt_q;
`endif

endmodule
